// File: rtl/cpu_ipl_gen_pkg.sv
// cpu_ipl_gen_pkg: shared constants and ack FSM encoding for the CPU interrupt level generator.
package cpu_ipl_gen_pkg;
  localparam logic [2:0] IPL_NONE = 3'd0;
  localparam logic [2:0] IPL_NMI = 3'd7;
  localparam logic [1:0] REARM_SAMPLES = 2'd2;
  typedef enum logic [1:0] {IDLE, ACK, WAIT_END} ack_state_t;
endpackage

// File: rtl/cpu_ipl_gen_filter.sv
// ipl_filter: presents a level only after two equal consecutive samples; mask7 forces the sample straight through.
module ipl_filter
  import cpu_ipl_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] d,
  input  logic       mask7,
  output logic [2:0] q
);
  logic [2:0] s_q, s_d, q_q, q_d;
  always_comb begin
    s_d = en ? d : s_q;
    q_d = en && (mask7 || d == s_q) ? d : q_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= IPL_NONE;
      q_q <= IPL_NONE;
    end else begin
      s_q <= s_d;
      q_q <= q_d;
    end
  end
  assign q = q_q;
endmodule

// File: rtl/cpu_ipl_gen.sv
// cpu_ipl_gen: filtered interrupt priority to the CPU, acknowledge-cycle detection and level-7 rearm.
module cpu_ipl_gen
  import cpu_ipl_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_clk_en,
  input  logic [2:0]  int_level,
  input  logic        int7,
  input  logic [23:1] cpu_address,
  input  logic        _cpu_as,
  input  logic        cpu_rd,
  output logic [2:0]  _ipl,
  output logic        iack,
  output logic [2:0]  iack_level,
  output logic        spurious
);
  ack_state_t state_q, state_d;
  logic [2:0] lvl, cand, filt_d, ipl_q, ipl_d, iack_level_q, iack_level_d;
  logic [1:0] rearm_q, rearm_d;
  logic       iack_q, iack_d, spur_q, spur_d, detect, rearm_load, mask7;
  ipl_filter u_filter (
    .clk  (clk),
    .reset(reset),
    .en   (cpu_clk_en),
    .d    (filt_d),
    .mask7(mask7),
    .q    (lvl)
  );
  // While rearming, level 7 is hidden so the CPU later sees a fresh 7 edge
  always_comb begin
    detect       = &cpu_address[23:4] && !_cpu_as && cpu_rd;
    cand         = int7 ? IPL_NMI : int_level;
    rearm_load   = state_q == ACK && iack_level_q == IPL_NMI;
    mask7        = rearm_load || rearm_q != 2'd0;
    filt_d       = mask7 ? int_level : cand;
    ipl_d        = ~lvl;
    rearm_d      = rearm_load ? REARM_SAMPLES : (cpu_clk_en && rearm_q != 2'd0) ? rearm_q - 2'd1 : rearm_q;
    state_d      = state_q == IDLE ? (detect ? ACK : IDLE) : state_q == ACK ? WAIT_END : (_cpu_as ? IDLE : WAIT_END);
    iack_d       = state_q == IDLE && detect;
    iack_level_d = iack_d ? cpu_address[3:1] : iack_level_q;
    spur_d       = iack_d && cpu_address[3:1] != lvl;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ipl_q        <= 3'b111;
      rearm_q      <= 2'd0;
      iack_q       <= 1'b0;
      iack_level_q <= IPL_NONE;
      spur_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ipl_q        <= ipl_d;
      rearm_q      <= rearm_d;
      iack_q       <= iack_d;
      iack_level_q <= iack_level_d;
      spur_q       <= spur_d;
    end
  end
  assign _ipl       = ipl_q;
  assign iack       = iack_q;
  assign iack_level = iack_level_q;
  assign spurious   = spur_q;
endmodule

// File: tb/tb_cpu_ipl_gen.sv
// tb_cpu_ipl_gen: directed and random stimulus checked every clock against a behavioural model.
module tb_cpu_ipl_gen;
  logic        clk = 1'b0;
  logic        reset, cpu_clk_en, int7, _cpu_as, cpu_rd, iack, spurious;
  logic [2:0]  int_level, _ipl, iack_level;
  logic [23:1] cpu_address;
  int checks = 0, errors = 0;
  int iack_cnt = 0, spur_cnt = 0, both_cnt = 0;
  int m_prev, m_lvl, m_ipl, m_rearm, m_phase, m_lev, m_iack, m_spur;
  always #5 clk = ~clk;
  cpu_ipl_gen dut (
    .clk(clk), .reset(reset), .cpu_clk_en(cpu_clk_en), .int_level(int_level), .int7(int7),
    .cpu_address(cpu_address), ._cpu_as(_cpu_as), .cpu_rd(cpu_rd),
    ._ipl(_ipl), .iack(iack), .iack_level(iack_level), .spurious(spurious)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset;
    m_prev = 0; m_lvl = 0; m_ipl = 7; m_rearm = 0; m_phase = 0; m_lev = 0; m_iack = 0; m_spur = 0;
  endtask
  task automatic tick;
    int n_prev, n_lvl, n_rearm, n_phase, n_lev, n_iack, n_spur, smp;
    bit det, forced;
    det = cpu_address[23:4] == 20'hFFFFF && !_cpu_as && cpu_rd;
    forced = (m_phase == 1 && m_lev == 7) || m_rearm > 0;
    n_prev = m_prev; n_lvl = m_lvl;
    if (cpu_clk_en) begin
      smp = forced ? int'(int_level) : (int7 ? 7 : int'(int_level));
      if (forced || smp == m_prev) n_lvl = smp;
      n_prev = smp;
    end
    n_rearm = m_rearm;
    if (m_phase == 1 && m_lev == 7) n_rearm = 2;
    else if (cpu_clk_en && m_rearm > 0) n_rearm = m_rearm - 1;
    n_iack = (m_phase == 0 && det) ? 1 : 0;
    n_lev = n_iack ? int'(cpu_address[3:1]) : m_lev;
    n_spur = (n_iack && int'(cpu_address[3:1]) != m_lvl) ? 1 : 0;
    n_phase = m_phase == 0 ? (det ? 1 : 0) : m_phase == 1 ? 2 : (_cpu_as ? 0 : 2);
    @(posedge clk);
    #1;
    if (reset) model_reset;
    else begin
      m_ipl = 7 - m_lvl;
      m_prev = n_prev; m_lvl = n_lvl; m_rearm = n_rearm; m_phase = n_phase;
      m_lev = n_lev; m_iack = n_iack; m_spur = n_spur;
    end
    chk("ipl", _ipl, m_ipl);
    chk("iack", iack, m_iack);
    chk("iack_level", iack_level, m_lev);
    chk("spurious", spurious, m_spur);
    iack_cnt += iack;
    spur_cnt += spurious;
    both_cnt += iack & spurious;
  endtask
  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      cpu_clk_en = (i % per) == per - 1;
      tick;
    end
    cpu_clk_en = 1'b0;
  endtask
  task automatic do_reset;
    _cpu_as = 1'b1; cpu_rd = 1'b0; cpu_address = '0; cpu_clk_en = 1'b0;
    reset = 1'b1;
    #1;
    model_reset;
    tick;
    reset = 1'b0;
  endtask
  task automatic ack_cycle(input logic [2:0] lev, input int low);
    iack_cnt = 0; spur_cnt = 0; both_cnt = 0;
    cpu_address = {20'hFFFFF, lev}; cpu_rd = 1'b1; _cpu_as = 1'b0;
    repeat (low) tick;
    _cpu_as = 1'b1; cpu_rd = 1'b0; cpu_address = '0;
    repeat (2) tick;
  endtask
  initial begin
    int strobe_left;
    int7 = 1'b0; int_level = 3'd0;
    do_reset;
    chk("rst_ipl", _ipl, 3'b111);
    chk("rst_iack", iack, 0);
    chk("rst_iack_level", iack_level, 0);
    chk("rst_spurious", spurious, 0);
    int_level = 3'd3;
    run(4, 4);
    chk("lvl3_first_sample", _ipl, 3'b111);
    run(4, 4);
    chk("lvl3_second_sample", _ipl, 3'b111);
    tick;
    chk("lvl3_presented", _ipl, 3'b100);
    do_reset;
    for (int s = 0; s < 10; s++) begin
      int_level = (s % 2) ? 3'd5 : 3'd2;
      run(4, 4);
    end
    tick;
    chk("toggle_stays_none", _ipl, 3'b111);
    do_reset;
    int7 = 1'b1; int_level = 3'd3;
    run(4, 4); run(4, 4); tick;
    chk("nmi_presented", _ipl, 3'b000);
    ack_cycle(3'd7, 6);
    chk("nmi_one_iack", iack_cnt, 1);
    chk("nmi_iack_level", iack_level, 7);
    chk("nmi_no_spurious", spur_cnt, 0);
    run(4, 4); run(4, 4);
    chk("rearm_shows_3", _ipl, 3'b100);
    run(4, 4);
    chk("rearm_still_3", _ipl, 3'b100);
    run(4, 4); tick;
    chk("nmi_edge_again", _ipl, 3'b000);
    int7 = 1'b0;
    do_reset;
    int_level = 3'd4;
    run(4, 4); run(4, 4); tick;
    chk("lvl4_presented", _ipl, 3'b011);
    ack_cycle(3'd2, 3);
    chk("spurious_with_iack", both_cnt, 1);
    chk("spurious_iack_level", iack_level, 2);
    cpu_address = {20'hFFFFF, 3'd4}; cpu_rd = 1'b1; _cpu_as = 1'b0;
    repeat (3) tick;
    #2;
    reset = 1'b1;
    #1;
    model_reset;
    chk("midack_rst_ipl", _ipl, 3'b111);
    chk("midack_rst_iack", iack, 0);
    chk("midack_rst_iack_level", iack_level, 0);
    chk("midack_rst_spurious", spurious, 0);
    _cpu_as = 1'b1; cpu_rd = 1'b0; cpu_address = '0;
    repeat (2) tick;
    reset = 1'b0;
    iack_cnt = 0;
    repeat (5) tick;
    chk("no_iack_after_rst", iack_cnt, 0);
    ack_cycle(3'd4, 3);
    chk("new_ack_after_rst", iack_cnt, 1);
    chk("new_ack_level", iack_level, 4);
    do_reset;
    strobe_left = 0;
    for (int c = 0; c < 600; c++) begin
      cpu_clk_en = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) int_level = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) int7 = ~int7;
      if (strobe_left > 0) begin
        strobe_left--;
        if (strobe_left == 0) begin _cpu_as = 1'b1; cpu_rd = 1'b0; end
      end else if (_cpu_as && $urandom_range(0, 15) == 0) begin
        cpu_address = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'hFFFFF, 3'($urandom_range(0, 7))};
        cpu_rd = $urandom_range(0, 5) != 0;
        _cpu_as = 1'b0;
        strobe_left = $urandom_range(1, 6);
      end
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
